// File: rtl/decode_stage.sv
// RV32I instruction-decode stage with ID/EX pipeline register.
// Holds the architectural register file (with optional write-back bypass),
// decodes every RV32I format, and detects load-use hazards against the
// instruction currently sitting in ID/EX.
module decode_stage #(
  parameter  int XLEN      = 32,
  parameter  int NREGS     = 32,
  parameter  int WB_BYPASS = 1,
  parameter  int HAZARD_EN = 1,
  localparam int RA_W      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_inst,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard_stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] reg1,
  output logic [XLEN-1:0] reg2,
  output logic [XLEN-1:0] imm,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [RA_W-1:0] rd,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Rounded up to a power of two so every RA_W-bit index is in range.
  localparam int RF_DEPTH = 2 ** RA_W;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } id_ex_t;

  logic [XLEN-1:0] rf_q [RF_DEPTH];
  logic [XLEN-1:0] rf_d [RF_DEPTH];

  id_ex_t id_ex_q, id_ex_d, dec;

  logic [6:0]      opc_in;
  logic [2:0]      f3_in;
  logic [RA_W-1:0] rs1_in, rs2_in, rd_in;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1_val, rd2_val;
  logic            uses_rs1, uses_rs2;
  logic            load_use;

  assign opc_in  = if_id_inst[6:0];
  assign f3_in   = if_id_inst[14:12];
  assign rs1_in  = if_id_inst[15 +: RA_W];
  assign rs2_in  = if_id_inst[20 +: RA_W];
  assign rd_in   = if_id_inst[7 +: RA_W];
  assign imm_ext = XLEN'($signed(imm32));

  // funct3 to ALU op; SUB only exists for register-register ops, shifts pick SRA via bit 30.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic b30,
                                         input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Register file next state: x0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (wb_we && (wb_rd != '0)) begin
      rf_d[wb_rd] = wb_data;
    end
  end

  // Register file storage; deliberately not reset.
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  // Operand reads: x0 reads zero, optional same-cycle bypass of the write-back port.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rs1_in != '0) begin
      rd1_val = rf_q[rs1_in];
      if ((WB_BYPASS != 0) && wb_we && (wb_rd == rs1_in)) begin
        rd1_val = wb_data;
      end
    end
    if (rs2_in != '0) begin
      rd2_val = rf_q[rs2_in];
      if ((WB_BYPASS != 0) && wb_we && (wb_rd == rs2_in)) begin
        rd2_val = wb_data;
      end
    end
  end

  // Immediate extraction by instruction format (32-bit, sign-extended to XLEN above).
  always_comb begin
    imm32 = '0;
    case (opc_in)
      OPC_IMM, OPC_LOAD, OPC_JALR:
        imm32 = {{20{if_id_inst[31]}}, if_id_inst[31:20]};
      OPC_STORE:
        imm32 = {{20{if_id_inst[31]}}, if_id_inst[31:25], if_id_inst[11:7]};
      OPC_BRANCH:
        imm32 = {{19{if_id_inst[31]}}, if_id_inst[31], if_id_inst[7],
                 if_id_inst[30:25], if_id_inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {if_id_inst[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{if_id_inst[31]}}, if_id_inst[31], if_id_inst[19:12],
                 if_id_inst[20], if_id_inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Full decode of the IF/ID instruction into an ID/EX record.
  always_comb begin
    dec           = '0;
    dec.valid     = if_id_valid;
    dec.pc        = if_id_pc;
    dec.reg1      = rd1_val;
    dec.reg2      = rd2_val;
    dec.imm       = imm_ext;
    dec.rs1       = rs1_in;
    dec.rs2       = rs2_in;
    dec.rd        = rd_in;
    dec.opcode    = opc_in;
    dec.funct3    = f3_in;
    case (opc_in)
      OPC_OP: begin
        dec.alu_op    = alu_sel(f3_in, if_id_inst[30], 1'b1);
        dec.reg_write = 1'b1;
      end
      OPC_IMM: begin
        dec.alu_op    = alu_sel(f3_in, if_id_inst[30], 1'b0);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op    = ALU_PASSB;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Load-use detection against the load currently held in ID/EX.
  always_comb begin
    uses_rs1 = !((opc_in == OPC_LUI) || (opc_in == OPC_AUIPC) || (opc_in == OPC_JAL));
    uses_rs2 = (opc_in == OPC_OP) || (opc_in == OPC_STORE) || (opc_in == OPC_BRANCH);
    load_use = if_id_valid && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
               ((uses_rs1 && (rs1_in == id_ex_q.rd)) || (uses_rs2 && (rs2_in == id_ex_q.rd)));
  end

  assign hazard_stall = (HAZARD_EN != 0) && load_use;

  // ID/EX next state: hold on stall, otherwise load decode, bubbling controls on flush/hazard.
  always_comb begin
    id_ex_d = id_ex_q;
    if (!stall) begin
      id_ex_d = dec;
      if (flush || hazard_stall) begin
        id_ex_d.valid     = 1'b0;
        id_ex_d.alu_op    = '0;
        id_ex_d.alu_src   = 1'b0;
        id_ex_d.reg_write = 1'b0;
        id_ex_d.mem_read  = 1'b0;
        id_ex_d.mem_write = 1'b0;
        id_ex_d.branch    = 1'b0;
        id_ex_d.jump      = 1'b0;
        id_ex_d.illegal   = 1'b0;
      end
    end
  end

  // ID/EX pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign id_ex_valid = id_ex_q.valid;
  assign id_ex_pc    = id_ex_q.pc;
  assign reg1        = id_ex_q.reg1;
  assign reg2        = id_ex_q.reg2;
  assign imm         = id_ex_q.imm;
  assign rs1         = id_ex_q.rs1;
  assign rs2         = id_ex_q.rs2;
  assign rd          = id_ex_q.rd;
  assign opcode      = id_ex_q.opcode;
  assign funct3      = id_ex_q.funct3;
  assign alu_op      = id_ex_q.alu_op;
  assign alu_src     = id_ex_q.alu_src;
  assign reg_write   = id_ex_q.reg_write;
  assign mem_read    = id_ex_q.mem_read;
  assign mem_write   = id_ex_q.mem_write;
  assign branch      = id_ex_q.branch;
  assign jump        = id_ex_q.jump;
  assign illegal     = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expectations are queued when an
// instruction is driven and compared one cycle later when ID/EX updates.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        hazard_stall;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, reg1, reg2, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
    .if_id_pc(if_id_pc), .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .hazard_stall(hazard_stall), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .reg1(reg1), .reg2(reg2), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rd(rd), .opcode(opcode), .funct3(funct3), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .illegal(illegal)
  );

  typedef struct {
    int          cyc;
    bit          dc_data;
    bit          dc_imm;
    logic        v;
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [3:0]  aop;
    logic        asrc, rw, mr, mw, br, jp, il;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf_m [32];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic compare(input exp_t e);
    check("valid", id_ex_valid, e.v);
    check("reg_write", reg_write, e.rw);
    check("mem_read", mem_read, e.mr);
    check("mem_write", mem_write, e.mw);
    check("branch", branch, e.br);
    check("jump", jump, e.jp);
    check("illegal", illegal, e.il);
    if (!e.dc_data) begin
      check("pc", id_ex_pc, e.pc);
      check("reg1", reg1, e.r1);
      check("reg2", reg2, e.r2);
      check("rs1", rs1, e.rs1);
      check("rs2", rs2, e.rs2);
      check("rd", rd, e.rd);
      check("opcode", opcode, e.opc);
      check("funct3", funct3, e.f3);
      check("alu_op", alu_op, e.aop);
      check("alu_src", alu_src, e.asrc);
      if (!e.dc_imm) check("imm", imm, e.imm);
    end
  endtask

  function automatic exp_t base(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e = '{default: 0};
    e.v   = 1'b1;
    e.pc  = pc;
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd  = inst[11:7];
    e.opc = inst[6:0];
    e.f3  = inst[14:12];
    e.r1  = rf_m[inst[19:15]];
    e.r2  = rf_m[inst[24:20]];
    return e;
  endfunction

  function automatic exp_t ctl(input exp_t ein, input logic [3:0] aop, input logic asrc,
                               input logic rw, input logic mr, input logic mw,
                               input logic br, input logic jp, input logic il);
    exp_t e;
    e = ein;
    e.aop = aop; e.asrc = asrc; e.rw = rw; e.mr = mr;
    e.mw = mw; e.br = br; e.jp = jp; e.il = il;
    return e;
  endfunction

  function automatic exp_t bubble(input exp_t ein);
    exp_t e;
    e = ctl(ein, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.v = 1'b0;
    e.dc_data = 1'b1;
    return e;
  endfunction

  function automatic void push(input exp_t ein);
    exp_t e;
    e = ein;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endfunction

  task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic stl, input logic fl);
    if_id_valid = v; if_id_inst = inst; if_id_pc = pc;
    stall = stl; flush = fl;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while ((sb.size() != 0) && (sb[0].cyc <= cyc)) begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_LW    = 32'h0000A303; // lw x6,0(x1)
  localparam logic [31:0] I_ADD7  = 32'h002303B3; // add x7,x6,x2
  localparam logic [31:0] I_LUI   = 32'h00030337; // lui x6,0x30 (rs1 field = 6)
  localparam logic [31:0] I_ADD4  = 32'h00018233; // add x4,x3,x0
  localparam logic [31:0] I_ADD8  = 32'h00000433; // add x8,x0,x0
  localparam logic [31:0] I_BEQ   = 32'hFE000CE3; // beq x0,x0,-8
  localparam logic [31:0] I_JAL   = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  initial begin
    exp_t e, e_lw, e_hold;
    exp_t e_zero;
    e_zero = '{default: 0};
    for (int i = 0; i < 32; i++) rf_m[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i * 32'h0001_0101;

    // Reset with random inputs on the ports
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_id_valid = 1'($urandom); if_id_inst = $urandom; if_id_pc = $urandom;
      stall = 1'($urandom); flush = 1'($urandom);
      wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      push(e_zero);
      tick();
      check("rst_hazard", hazard_stall, 1'b0);
    end
    reset = 1'b0;

    // Preload x1..x31 with known values through write-back
    for (int i = 1; i < 32; i++) begin
      set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      wb_we = 1'b1; wb_rd = 5'(i); wb_data = rf_m[i];
      tick();
    end

    // addi x5,x0,-1
    set_in(1'b1, I_ADDI, 32'h1000, 1'b0, 1'b0);
    e = ctl(base(I_ADDI, 32'h1000), 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.imm = 32'hFFFF_FFFF;
    push(e); tick();

    // lw then dependent add: one bubble, then add issues
    set_in(1'b1, I_LW, 32'h1004, 1'b0, 1'b0);
    e_lw = ctl(base(I_LW, 32'h1004), 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_lw.imm = 32'h0;
    push(e_lw); tick();
    set_in(1'b1, I_ADD7, 32'h1008, 1'b0, 1'b0);
    #1 check("hz_lw_add", hazard_stall, 1'b1);
    push(bubble(base(I_ADD7, 32'h1008))); tick();
    #1 check("hz_cleared", hazard_stall, 1'b0);
    e = ctl(base(I_ADD7, 32'h1008), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.dc_imm = 1'b1;
    push(e); tick();

    // lui does not read rs1, so no hazard even though its rs1 field matches
    set_in(1'b1, I_LW, 32'h100C, 1'b0, 1'b0);
    e_lw.pc = 32'h100C;
    push(e_lw); tick();
    set_in(1'b1, I_LUI, 32'h1010, 1'b0, 1'b0);
    #1 check("hz_lui", hazard_stall, 1'b0);
    e = ctl(base(I_LUI, 32'h1010), 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.imm = 32'h0003_0000;
    push(e); tick();

    // hazard under external stall: hold wins, hazard re-evaluated afterwards
    set_in(1'b1, I_LW, 32'h1014, 1'b0, 1'b0);
    e_lw.pc = 32'h1014;
    push(e_lw); tick();
    set_in(1'b1, I_ADD7, 32'h1018, 1'b1, 1'b0);
    #1 check("hz_in_stall", hazard_stall, 1'b1);
    push(e_lw); tick();
    set_in(1'b1, I_ADD7, 32'h1018, 1'b0, 1'b0);
    #1 check("hz_after_stall", hazard_stall, 1'b1);
    push(bubble(base(I_ADD7, 32'h1018))); tick();
    e = ctl(base(I_ADD7, 32'h1018), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.dc_imm = 1'b1;
    push(e); tick();

    // write-back bypass into rs1, then the written value read from the file
    set_in(1'b1, I_ADD4, 32'h101C, 1'b0, 1'b0);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5A5_A5A5;
    rf_m[3] = 32'hA5A5_A5A5;
    e = ctl(base(I_ADD4, 32'h101C), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.dc_imm = 1'b1;
    push(e); tick();
    set_in(1'b1, I_ADD4, 32'h1020, 1'b0, 1'b0);
    e.pc = 32'h1020;
    push(e); tick();

    // write-back to x0 neither bypasses nor sticks
    set_in(1'b1, I_ADD8, 32'h1024, 1'b0, 1'b0);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    e = ctl(base(I_ADD8, 32'h1024), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.dc_imm = 1'b1;
    push(e); tick();
    set_in(1'b1, I_ADD8, 32'h1028, 1'b0, 1'b0);
    e.pc = 32'h1028;
    push(e); tick();

    // beq -8 with flush (bubble), then without flush
    set_in(1'b1, I_BEQ, 32'h102C, 1'b0, 1'b1);
    push(bubble(base(I_BEQ, 32'h102C))); tick();
    set_in(1'b1, I_BEQ, 32'h1030, 1'b0, 1'b0);
    e_hold = ctl(base(I_BEQ, 32'h1030), 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_hold.imm = 32'hFFFF_FFF8;
    push(e_hold); tick();
    // stall beats flush
    set_in(1'b1, I_ADDI, 32'h1034, 1'b1, 1'b1);
    push(e_hold); tick();

    // jal +2048, then three stalled cycles with other inputs, then an illegal opcode
    set_in(1'b1, I_JAL, 32'h1038, 1'b0, 1'b0);
    e_hold = ctl(base(I_JAL, 32'h1038), 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_hold.imm = 32'h0000_0800;
    push(e_hold); tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, I_ILL, 32'h2000 + 32'(k), 1'b1, 1'b0);
      push(e_hold); tick();
    end
    set_in(1'b1, I_ILL, 32'h103C, 1'b0, 1'b0);
    e = ctl(base(I_ILL, 32'h103C), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e.dc_imm = 1'b1;
    push(e); tick();

    // reset while stalled clears ID/EX on the next edge
    set_in(1'b1, I_ADDI, 32'h1040, 1'b0, 1'b0);
    tick();
    set_in(1'b1, I_ADDI, 32'h1044, 1'b1, 1'b0);
    reset = 1'b1;
    push(e_zero); tick();
    reset = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
